wb_pipe_stage: RTL and testbench
================================

# wb_pipe_stage

Parametrised, flow-controlled pipeline stage register for the MEM→WB boundary and any other inter-stage boundary of the core. It generalises the fixed-field stage register: the payload width and the control-field width are parameters. It adds valid/ready back-pressure, an optional 2-entry skid buffer that keeps `in_ready` registered, and a synchronous flush. It also forces bubbles, so a non-valid output never carries live control bits such as a RegWrite that should not fire.

## Interface
- `DATA_W`, default 101: payload width, meaning ALU result, read data, write address and PC+4 concatenated. Data is never cleared by a bubble.
- `CTRL_W`, default 3: control-field width, meaning RegWrite and ResultSrc. Zeroed whenever the output is not valid.
- `SKID`, default 1: 1 selects the 2-entry skid mode; 0 selects the single-register mode with a combinational `in_ready`.
- `clk`  in  1  clock. All state updates on the falling edge, as in every pipeline register of the core.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous kill of every held and incoming entry.
- `in_valid`  in  1  upstream entry present.
- `in_ready`  out  1  stage can accept an entry this cycle.
- `in_data`  in  DATA_W  upstream payload.
- `in_ctrl`  in  CTRL_W  upstream control bits.
- `out_valid`  out  1  entry presented downstream.
- `out_ready`  in  1  downstream accepts the entry this cycle.
- `out_data`  out  DATA_W  payload of the head entry.
- `out_ctrl`  out  CTRL_W  control bits of the head entry; 0 when `out_valid`=0.
- `occupancy`  out  2  number of held entries, 0..2.

## Operation
- Transfer rules:
  - in-fire = `in_valid & in_ready`.
  - out-fire = `out_valid & out_ready`.
  - Both are evaluated on the same falling edge.
- Storage: a head register (`main`) and, for SKID=1 only, a skid register. Each holds data, ctrl and a valid bit.
- SKID=1 state machine, with `in_ready` = ~skid_valid taken straight from a flop:
  - EMPTY: in-fire → main ← in, go to ONE.
  - ONE, in-fire & out-fire → main ← in, stay in ONE.
  - ONE, in-fire only → skid ← in, go to FULL.
  - ONE, out-fire only → go to EMPTY.
  - ONE, neither → hold.
  - FULL (`in_ready`=0): out-fire → main ← skid, skid invalidated, go to ONE. Otherwise hold.
- SKID=0:
  - `in_ready` = ~main_valid | out_ready.
  - in-fire → main ← in, valid ← 1.
  - out-fire without in-fire → valid ← 0.
  - `occupancy` is 0 or 1.
- Output assignments:
  - `out_valid` = main_valid.
  - `out_data` = main_data. It holds its last value when not valid.
  - `out_ctrl` = main_ctrl & {CTRL_W{main_valid}}.
- Flush has highest priority:
  - Next state is EMPTY.
  - All ctrl fields and valid bits are cleared; data fields are cleared to 0.
  - An entry firing into the stage in the same cycle is discarded.
  - `in_ready` is still driven per the current state during the flush cycle, so upstream treats that entry as consumed.
- Ordering: strictly FIFO. No entry is duplicated or dropped except by flush.

## Timing
- Reset (`reset`=0, asynchronous):
  - State is EMPTY.
  - All data and ctrl registers are 0.
  - `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0.
  - `in_ready`=1.
  - Outputs stay at these values until the first falling edge after `reset` rises.
- Reset asserted mid-operation: held entries are lost immediately, with no wait for a clock edge.
- Latency: an entry accepted at falling edge N is on the outputs from edge N, i.e. visible to downstream logic for the following half/full cycle. Stage latency is 1 edge.
- Throughput: 1 entry per cycle with `out_ready` continuously high, in both modes.
- SKID=1 handshake timing:
  - After `out_ready` falls, the stage absorbs at most one further entry, then deasserts `in_ready` on the next edge.
  - `in_ready` reasserts on the edge where a FULL → ONE drain occurs.
- Simultaneous events:
  - In FULL with out-fire, `in_ready`=0, so no entry is accepted on that edge.
  - In EMPTY with out_ready=1, `out_valid` is 0 and nothing drains.
- `occupancy` updates on the same edge as the state change.

## Test plan
- Reset:
  - Stimulus: pulse `reset` low between edges with `in_valid`=1 and `in_data`=0x1234.
  - Required response: outputs drop asynchronously to 0; `in_ready`=1; `occupancy`=0; nothing is captured while `reset`=0.
- Streaming:
  - Stimulus: SKID=1, `out_ready`=1, 8 entries with data 1..8 and ctrl 3'b101.
  - Required response: one entry per cycle, in order, 1 edge of latency; `occupancy` stays at 1 during streaming and drops to 0 once the stream ends.
- Back-pressure:
  - Stimulus: send A, B, C with `out_ready`=0.
  - Required response: A on the output; B in skid; `occupancy`=2; `in_ready`=0; C held upstream. Then raise `out_ready`: output sequence is A, B, C with no loss.
- Flush:
  - Stimulus: assert `flush` in state FULL with `in_valid`=1 and data D.
  - Required response: next edge gives EMPTY; `out_valid`=0; `out_ctrl`=0; `out_data`=0; D is never seen at the output.
- Bubble:
  - Stimulus: accept ctrl 3'b111, then drain with `in_valid`=0.
  - Required response: `out_ctrl`=0 while `out_data` keeps the last payload.
- SKID=0 mode:
  - Stimulus: `out_ready`=0 while holding 1 entry; then apply out_ready=1 and in_valid=1 in the same cycle.
  - Required response: while stalled, `in_ready`=0. With both high, `in_ready`=1 combinationally and the entry is replaced on the same edge, sustaining 1 entry per cycle.

Source files
------------

// File: rtl/wb_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module  : wb_pipe_stage
// Purpose : Valid/ready pipeline stage register with optional 2-entry skid
//           buffer, synchronous flush and bubble-forced control bits.
// Rev     : 1.0  initial release
// ============================================================================
module wb_pipe_stage #(
    parameter int DATA_W = 101,
    parameter int CTRL_W = 3,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    // Bit 0 of the encoding is the head valid bit, bit 1 the skid valid bit,
    // so both valids (and in_ready in skid mode) come straight off state flops.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_main_data;
    logic [DATA_W-1:0]   w_main_data_nxt;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [CTRL_W-1:0]   w_main_ctrl_nxt;
    logic [DATA_W-1:0]   r_skid_data;
    logic [DATA_W-1:0]   w_skid_data_nxt;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [CTRL_W-1:0]   w_skid_ctrl_nxt;

    logic                w_main_valid;
    logic                w_skid_valid;
    logic                w_in_fire;
    logic                w_out_fire;

    assign w_main_valid = r_state[0];
    assign w_skid_valid = r_state[1];

    generate
        if (SKID != 0) begin : g_ready_skid
            assign in_ready = ~w_skid_valid;
        end else begin : g_ready_comb
            assign in_ready = ~w_main_valid | out_ready;
        end
    endgenerate

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = w_main_valid & out_ready;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_EMPTY;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_main_data <= w_main_data_nxt;
            r_main_ctrl <= w_main_ctrl_nxt;
            r_skid_data <= w_skid_data_nxt;
            r_skid_ctrl <= w_skid_ctrl_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_main_data_nxt = r_main_data;
        w_main_ctrl_nxt = r_main_ctrl;
        w_skid_data_nxt = r_skid_data;
        w_skid_ctrl_nxt = r_skid_ctrl;

        if (flush) begin
            // Anything entering on this edge is dropped even though in_ready
            // told upstream it was consumed.
            w_state_nxt     = ST_EMPTY;
            w_main_data_nxt = '0;
            w_main_ctrl_nxt = '0;
            w_skid_data_nxt = '0;
            w_skid_ctrl_nxt = '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_main_data_nxt = in_data;
                        w_main_ctrl_nxt = in_ctrl;
                        w_state_nxt     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_data_nxt = in_data;
                        w_main_ctrl_nxt = in_ctrl;
                    end else if (w_in_fire) begin
                        // Only reachable in skid mode: without a skid entry,
                        // in_ready is low whenever the head is stalled.
                        if (SKID != 0) begin
                            w_skid_data_nxt = in_data;
                            w_skid_ctrl_nxt = in_ctrl;
                            w_state_nxt     = ST_FULL;
                        end
                    end else if (w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_main_data_nxt = r_skid_data;
                        w_main_ctrl_nxt = r_skid_ctrl;
                        w_skid_ctrl_nxt = '0;
                        w_state_nxt     = ST_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    assign out_valid = w_main_valid;
    assign out_data  = r_main_data;
    assign out_ctrl  = r_main_ctrl & {CTRL_W{w_main_valid}};
    assign occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

endmodule
`default_nettype wire

// File: tb/tb_wb_pipe_stage.sv
`default_nettype none
// Self-checking bench for wb_pipe_stage: skid-mode instance driven through a
// scoreboard, plus a single-register instance checked directly.
module tb_wb_pipe_stage;

    localparam int DW = 101;
    localparam int CW = 3;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } entry_t;

    logic          clk;
    logic          reset;
    logic          flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [1:0]    occupancy;

    logic          n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [DW-1:0] n_in_data, n_out_data;
    logic [CW-1:0] n_in_ctrl, n_out_ctrl;
    logic [1:0]    n_occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    entry_t        sb_q[$];
    entry_t        s_exp;
    logic          s_in_ready, s_out_valid, s_out_fire, s_pop_ok;
    logic [DW-1:0] s_out_data;
    logic [CW-1:0] s_out_ctrl;
    logic [1:0]    s_occ;

    wb_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_skid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy)
    );

    wb_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_noskid (
        .clk(clk), .reset(reset), .flush(n_flush),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data), .in_ctrl(n_in_ctrl),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data), .out_ctrl(n_out_ctrl),
        .occupancy(n_occupancy)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "timeout");
    end

    // One cycle on the skid instance: drive, sample on the rising (inactive)
    // edge, update the scoreboard, and return just after the falling edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic ordy, input logic fl);
        entry_t e;
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_out_data  = out_data;
        s_out_ctrl  = out_ctrl;
        s_occ       = occupancy;
        s_out_fire  = out_valid & ordy;
        s_pop_ok    = 1'b0;
        if (s_out_fire && sb_q.size() > 0) begin
            s_exp    = sb_q.pop_front();
            s_pop_ok = 1'b1;
        end
        if (fl) begin
            sb_q.delete();
        end else if (v && in_ready) begin
            e.d = d;
            e.c = c;
            sb_q.push_back(e);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        flush = 0; in_valid = 1; in_data = DW'('h1234); in_ctrl = 3'b101; out_ready = 0;
        n_flush = 0; n_in_valid = 0; n_in_data = '0; n_in_ctrl = '0; n_out_ready = 0;
        #1 reset = 1'b0;
        #2;
        n_tests++;
        if ({out_valid, out_ctrl, occupancy, in_ready} !== {1'b0, 3'b000, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b c=%b occ=%0d rdy=%b, want v=0 c=000 occ=0 rdy=1",
                     out_valid, out_ctrl, occupancy, in_ready);
        end
        n_tests++;
        if (out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, want 0", out_data);
        end
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_no_capture: got v=%b occ=%0d d=%h, want v=0 occ=0 d=0",
                     out_valid, occupancy, out_data);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== DW'('h1234) || out_ctrl !== 3'b101) begin
            n_fail++;
            $display("FAIL reset_first_capture: got v=%b d=%h c=%b, want v=1 d=1234 c=101",
                     out_valid, out_data, out_ctrl);
        end
        in_valid = 0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, out_ctrl, occupancy, in_ready} !== {1'b0, 3'b000, 2'd0, 1'b1} ||
            out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got v=%b c=%b occ=%0d rdy=%b d=%h, want 0/000/0/1/0",
                     out_valid, out_ctrl, occupancy, in_ready, out_data);
        end
        @(negedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) cycle(1'b1, DW'(i), 3'b101, 1'b1, 1'b0);
            else        cycle(1'b0, '0, '0, 1'b1, 1'b0);
            n_tests++;
            if (i == 1) begin
                if (s_out_valid !== 1'b0 || s_occ !== 2'd0) begin
                    n_fail++;
                    $display("FAIL stream_start: got v=%b occ=%0d, want v=0 occ=0", s_out_valid, s_occ);
                end
            end else begin
                if (!s_out_fire || !s_pop_ok || s_out_data !== s_exp.d || s_out_ctrl !== s_exp.c ||
                    s_occ !== 2'd1) begin
                    n_fail++;
                    $display("FAIL stream_entry%0d: got v=%b d=%h c=%b occ=%0d, want v=1 d=%h c=%b occ=1",
                             i - 1, s_out_valid, s_out_data, s_out_ctrl, s_occ, s_exp.d, s_exp.c);
                end
            end
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        n_tests++;
        if (s_out_valid !== 1'b0 || s_occ !== 2'd0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL stream_end: got v=%b occ=%0d pending=%0d, want v=0 occ=0 pending=0",
                     s_out_valid, s_occ, sb_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic          v_t  [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
        logic [7:0]    d_t  [8] = '{8'hA1, 8'hB2, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'h00, 8'h00};
        logic          r_t  [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        logic          er_t [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
        logic [1:0]    eo_t [8] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
        logic          ef_t [8] = '{0, 0, 0, 0, 1, 1, 1, 0};
        for (int k = 0; k < 8; k++) begin
            cycle(v_t[k], DW'(d_t[k]), d_t[k][2:0], r_t[k], 1'b0);
            n_tests++;
            if (s_in_ready !== er_t[k] || s_occ !== eo_t[k] || s_out_fire !== ef_t[k]) begin
                n_fail++;
                $display("FAIL bp_step%0d: got rdy=%b occ=%0d fire=%b, want rdy=%b occ=%0d fire=%b",
                         k, s_in_ready, s_occ, s_out_fire, er_t[k], eo_t[k], ef_t[k]);
            end
            if (s_out_fire) begin
                n_tests++;
                if (!s_pop_ok || s_out_data !== s_exp.d || s_out_ctrl !== s_exp.c) begin
                    n_fail++;
                    $display("FAIL bp_order%0d: got d=%h c=%b, want d=%h c=%b",
                             k, s_out_data, s_out_ctrl, s_exp.d, s_exp.c);
                end
            end
        end
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drained: got pending=%0d, want 0", sb_q.size());
        end
    endtask

    task automatic test_flush();
        cycle(1'b1, DW'('h11), 3'b011, 1'b0, 1'b0);
        cycle(1'b1, DW'('h22), 3'b110, 1'b0, 1'b0);
        cycle(1'b1, DW'('hDD), 3'b111, 1'b0, 1'b1);
        n_tests++;
        if (s_in_ready !== 1'b0 || s_occ !== 2'd2) begin
            n_fail++;
            $display("FAIL flush_full_state: got rdy=%b occ=%0d, want rdy=0 occ=2", s_in_ready, s_occ);
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        n_tests++;
        if ({s_out_valid, s_out_ctrl, s_occ, s_in_ready} !== {1'b0, 3'b000, 2'd0, 1'b1} ||
            s_out_data !== '0) begin
            n_fail++;
            $display("FAIL flush_full: got v=%b c=%b occ=%0d rdy=%b d=%h, want 0/000/0/1/0",
                     s_out_valid, s_out_ctrl, s_occ, s_in_ready, s_out_data);
        end
        cycle(1'b1, DW'('h33), 3'b101, 1'b0, 1'b0);
        cycle(1'b1, DW'('hEE), 3'b111, 1'b0, 1'b1);
        n_tests++;
        if (s_in_ready !== 1'b1 || s_out_data !== DW'('h33)) begin
            n_fail++;
            $display("FAIL flush_one_state: got rdy=%b d=%h, want rdy=1 d=33", s_in_ready, s_out_data);
        end
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0);
            n_tests++;
            if (s_out_valid !== 1'b0 || s_out_data !== '0 || s_out_ctrl !== '0 || s_occ !== 2'd0) begin
                n_fail++;
                $display("FAIL flush_discard%0d: got v=%b d=%h c=%b occ=%0d, want v=0 d=0 c=000 occ=0",
                         k, s_out_valid, s_out_data, s_out_ctrl, s_occ);
            end
        end
    endtask

    task automatic test_bubble();
        cycle(1'b1, DW'('hABC), 3'b111, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        n_tests++;
        if (!s_out_fire || !s_pop_ok || s_out_data !== s_exp.d || s_out_ctrl !== s_exp.c) begin
            n_fail++;
            $display("FAIL bubble_live: got v=%b d=%h c=%b, want v=1 d=%h c=%b",
                     s_out_valid, s_out_data, s_out_ctrl, s_exp.d, s_exp.c);
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        n_tests++;
        if (s_out_valid !== 1'b0 || s_out_ctrl !== 3'b000 || s_out_data !== DW'('hABC)) begin
            n_fail++;
            $display("FAIL bubble_masked: got v=%b c=%b d=%h, want v=0 c=000 d=abc",
                     s_out_valid, s_out_ctrl, s_out_data);
        end
    endtask

    task automatic test_noskid();
        n_in_valid = 1; n_in_data = DW'('h55); n_in_ctrl = 3'b011; n_out_ready = 0;
        @(posedge clk);
        n_tests++;
        if (n_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL noskid_empty_ready: got %b, want 1", n_in_ready);
        end
        @(negedge clk);
        #1 n_in_data = DW'('h66);
        @(posedge clk);
        n_tests++;
        if (n_in_ready !== 1'b0 || n_out_valid !== 1'b1 || n_out_data !== DW'('h55) ||
            n_out_ctrl !== 3'b011 || n_occupancy !== 2'd1) begin
            n_fail++;
            $display("FAIL noskid_stall: got rdy=%b v=%b d=%h c=%b occ=%0d, want rdy=0 v=1 d=55 c=011 occ=1",
                     n_in_ready, n_out_valid, n_out_data, n_out_ctrl, n_occupancy);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (n_out_data !== DW'('h55)) begin
            n_fail++;
            $display("FAIL noskid_hold: got d=%h, want 55", n_out_data);
        end
        n_out_ready = 1;
        #1;
        n_tests++;
        if (n_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL noskid_comb_ready: got %b, want 1", n_in_ready);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (n_out_valid !== 1'b1 || n_out_data !== DW'('h66) || n_occupancy !== 2'd1) begin
            n_fail++;
            $display("FAIL noskid_replace: got v=%b d=%h occ=%0d, want v=1 d=66 occ=1",
                     n_out_valid, n_out_data, n_occupancy);
        end
        for (int k = 0; k < 4; k++) begin
            n_in_data = DW'(8'h70 + k);
            @(negedge clk);
            #1;
            n_tests++;
            if (n_out_valid !== 1'b1 || n_out_data !== DW'(8'h70 + k) || n_in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL noskid_stream%0d: got v=%b d=%h rdy=%b, want v=1 d=%h rdy=1",
                         k, n_out_valid, n_out_data, n_in_ready, DW'(8'h70 + k));
            end
        end
        n_in_valid = 0;
        @(negedge clk);
        #1;
        n_tests++;
        if (n_out_valid !== 1'b0 || n_out_ctrl !== 3'b000 || n_occupancy !== 2'd0 ||
            n_out_data !== DW'('h73)) begin
            n_fail++;
            $display("FAIL noskid_drain: got v=%b c=%b occ=%0d d=%h, want v=0 c=000 occ=0 d=73",
                     n_out_valid, n_out_ctrl, n_occupancy, n_out_data);
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_bubble();
        test_noskid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
